// File: rtl/br_fifo_shared_pkg.sv
// br_fifo_shared_pkg: shared types and width helpers for the shared multi-FIFO linked-list logic
package br_fifo_shared_pkg;
  typedef enum logic [1:0] {EMPTY, HEAD, PEND} ll_state_e;
  function automatic int addr_width(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/br_fifo_shared_dynamic_tail_linker.sv
// br_fifo_shared_dynamic_tail_linker: chains same-cycle pushes in port order onto the list tail
module br_fifo_shared_dynamic_tail_linker #(
  parameter int NumWritePorts = 1,
  parameter int AddrWidth = 1
) (
  input  logic [NumWritePorts-1:0]           i_next_tail_valid,
  input  logic [NumWritePorts*AddrWidth-1:0] i_next_tail,
  input  logic [AddrWidth-1:0]               i_tail,
  input  logic                               i_list_empty,
  output logic [NumWritePorts-1:0]           o_wr_valid,
  output logic [NumWritePorts*AddrWidth-1:0] o_wr_addr,
  output logic [NumWritePorts*AddrWidth-1:0] o_wr_data,
  output logic                               o_head_cand_valid,
  output logic [AddrWidth-1:0]               o_head_cand,
  output logic [AddrWidth-1:0]               o_tail_next
);
  logic [AddrWidth-1:0] w_pred;
  logic w_linked;
  assign o_wr_data = i_next_tail;
  assign o_tail_next = w_pred;
  // Only the first pushing port of an empty list lacks a predecessor and becomes the head.
  always_comb begin
    w_pred = i_tail;
    w_linked = ~i_list_empty;
    o_wr_valid = '0;
    o_wr_addr = '0;
    o_head_cand_valid = 1'b0;
    o_head_cand = '0;
    for (int k = 0; k < NumWritePorts; k++) begin
      if (i_next_tail_valid[k]) begin
        o_wr_valid[k] = w_linked;
        o_wr_addr[k*AddrWidth+:AddrWidth] = w_pred;
        if (!w_linked) begin
          o_head_cand_valid = 1'b1;
          o_head_cand = i_next_tail[k*AddrWidth+:AddrWidth];
        end
        w_pred = i_next_tail[k*AddrWidth+:AddrWidth];
        w_linked = 1'b1;
      end
    end
  end
endmodule

// File: rtl/br_fifo_shared_dynamic_linked_list_ctrl.sv
// br_fifo_shared_dynamic_linked_list_ctrl: per-FIFO head/tail/count tracker over a shared pointer RAM
module br_fifo_shared_dynamic_linked_list_ctrl
  import br_fifo_shared_pkg::*;
#(
  parameter int NumWritePorts = 1,
  parameter int Depth = 3,
  parameter int PointerRamReadLatency = 0,
  localparam int AddrWidth = addr_width(Depth),
  localparam int CountWidth = count_width(Depth)
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [NumWritePorts-1:0]           i_next_tail_valid,
  input  logic [NumWritePorts*AddrWidth-1:0] i_next_tail,
  output logic [NumWritePorts-1:0]           o_ptr_ram_wr_valid,
  output logic [NumWritePorts*AddrWidth-1:0] o_ptr_ram_wr_addr,
  output logic [NumWritePorts*AddrWidth-1:0] o_ptr_ram_wr_data,
  output logic                               o_ptr_ram_rd_addr_valid,
  output logic [AddrWidth-1:0]               o_ptr_ram_rd_addr,
  input  logic                               i_ptr_ram_rd_data_valid,
  input  logic [AddrWidth-1:0]               i_ptr_ram_rd_data,
  output logic                               o_head_valid,
  output logic [AddrWidth-1:0]               o_head,
  input  logic                               i_head_ready,
  output logic [CountWidth-1:0]              o_count
);
  ll_state_e r_state;
  logic [AddrWidth-1:0] r_head, r_tail, w_tail_next, w_head_cand;
  logic [CountWidth-1:0] r_count, w_push_cnt;
  logic w_pop, w_list_empty, w_head_cand_valid;
  assign o_head_valid = r_state == HEAD;
  assign o_head = r_head;
  assign o_count = r_count;
  assign w_pop = o_head_valid & i_head_ready;
  assign w_list_empty = r_count == '0 || (r_count == CountWidth'(1) && w_pop);
  assign o_ptr_ram_rd_addr_valid = w_pop & ~w_list_empty;
  assign o_ptr_ram_rd_addr = r_head;
  always_comb begin
    w_push_cnt = '0;
    for (int k = 0; k < NumWritePorts; k++) w_push_cnt = w_push_cnt + CountWidth'(i_next_tail_valid[k]);
  end
  br_fifo_shared_dynamic_tail_linker #(
    .NumWritePorts(NumWritePorts),
    .AddrWidth(AddrWidth)
  ) u_linker (
    .i_next_tail_valid(i_next_tail_valid),
    .i_next_tail(i_next_tail),
    .i_tail(r_tail),
    .i_list_empty(w_list_empty),
    .o_wr_valid(o_ptr_ram_wr_valid),
    .o_wr_addr(o_ptr_ram_wr_addr),
    .o_wr_data(o_ptr_ram_wr_data),
    .o_head_cand_valid(w_head_cand_valid),
    .o_head_cand(w_head_cand),
    .o_tail_next(w_tail_next)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= EMPTY;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else begin
      r_count <= r_count + w_push_cnt - CountWidth'(w_pop);
      if (|i_next_tail_valid) r_tail <= w_tail_next;
      case (r_state)
        EMPTY: if (w_head_cand_valid) begin
          r_head <= w_head_cand;
          r_state <= HEAD;
        end
        HEAD: if (w_pop) begin
          // A last-entry pop with a same-cycle push hands the new entry straight to head.
          if (w_list_empty) begin
            if (w_head_cand_valid) r_head <= w_head_cand;
            else r_state <= EMPTY;
          end else if (PointerRamReadLatency == 0) r_head <= i_ptr_ram_rd_data;
          else r_state <= PEND;
        end
        PEND: if (i_ptr_ram_rd_data_valid) begin
          r_head <= i_ptr_ram_rd_data;
          r_state <= HEAD;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end
  assert property (@(posedge i_clk) disable iff (!i_rst_n) int'(r_count) + int'(w_push_cnt) <= Depth);
  assert property (@(posedge i_clk) disable iff (!i_rst_n) i_head_ready |-> o_head_valid);
endmodule

// File: tb/tb_br_fifo_shared_dynamic_linked_list_ctrl.sv
// tb_br_fifo_shared_dynamic_linked_list_ctrl: scoreboard bench for a zero-latency and a two-cycle-latency instance
module tb_br_fifo_shared_dynamic_linked_list_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic a_rst_n, b_rst_n;
  logic [2:0] a_ntv, b_ntv, a_wv, b_wv;
  logic [8:0] a_nt, b_nt, a_wa, a_wd, b_wa, b_wd;
  logic a_hr, b_hr, a_rav, b_rav, a_rdv, b_rdv, a_hv, b_hv;
  logic [2:0] a_ra, b_ra, a_rd, b_rd, a_head, b_head;
  logic [3:0] a_count, b_count;
  logic [2:0] ram_a [8];
  logic [2:0] ram_b [8];
  logic [1:0] b_pv = 2'b00;
  logic [2:0] b_pa [2];
  int q [6][$];
  int n_checks = 0, n_errors = 0;
  localparam int WA = 0, RA = 1, HA = 2, WB = 3, RB = 4, HB = 5;

  br_fifo_shared_dynamic_linked_list_ctrl #(.NumWritePorts(3), .Depth(8), .PointerRamReadLatency(0)) dut_a (
    .i_clk(clk), .i_rst_n(a_rst_n), .i_next_tail_valid(a_ntv), .i_next_tail(a_nt),
    .o_ptr_ram_wr_valid(a_wv), .o_ptr_ram_wr_addr(a_wa), .o_ptr_ram_wr_data(a_wd),
    .o_ptr_ram_rd_addr_valid(a_rav), .o_ptr_ram_rd_addr(a_ra),
    .i_ptr_ram_rd_data_valid(a_rdv), .i_ptr_ram_rd_data(a_rd),
    .o_head_valid(a_hv), .o_head(a_head), .i_head_ready(a_hr), .o_count(a_count));
  br_fifo_shared_dynamic_linked_list_ctrl #(.NumWritePorts(3), .Depth(8), .PointerRamReadLatency(2)) dut_b (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_next_tail_valid(b_ntv), .i_next_tail(b_nt),
    .o_ptr_ram_wr_valid(b_wv), .o_ptr_ram_wr_addr(b_wa), .o_ptr_ram_wr_data(b_wd),
    .o_ptr_ram_rd_addr_valid(b_rav), .o_ptr_ram_rd_addr(b_ra),
    .i_ptr_ram_rd_data_valid(b_rdv), .i_ptr_ram_rd_data(b_rd),
    .o_head_valid(b_hv), .o_head(b_head), .i_head_ready(b_hr), .o_count(b_count));

  // Pointer RAM stand-ins: A answers in the request cycle, B two cycles later through a pipe that reset does not flush.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (a_wv[k]) ram_a[a_wa[k*3+:3]] <= a_wd[k*3+:3];
      if (b_wv[k]) ram_b[b_wa[k*3+:3]] <= b_wd[k*3+:3];
    end
    b_pv <= {b_pv[0], b_rav};
    b_pa[1] <= b_pa[0];
    b_pa[0] <= b_ra;
  end
  assign a_rdv = a_rav;
  assign a_rd = ram_a[a_ra];
  assign b_rdv = b_pv[1];
  assign b_rd = ram_b[b_pa[1]];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic sb(input int idx, input string nm, input int act);
    if (q[idx].size() == 0) chk({nm, "_unexpected"}, act, -1);
    else chk(nm, act, q[idx].pop_front());
  endtask
  function automatic int wr_code(input int p, input int a, input int d);
    return p * 64 + a * 8 + d;
  endfunction

  always @(negedge clk) begin
    if (a_rst_n) begin
      for (int k = 0; k < 3; k++) if (a_wv[k]) sb(WA, "a_wr", wr_code(k, int'(a_wa[k*3+:3]), int'(a_wd[k*3+:3])));
      if (a_rav) sb(RA, "a_rd_addr", int'(a_ra));
      if (a_hv && a_hr) sb(HA, "a_pop_head", int'(a_head));
    end
    if (b_rst_n) begin
      for (int k = 0; k < 3; k++) if (b_wv[k]) sb(WB, "b_wr", wr_code(k, int'(b_wa[k*3+:3]), int'(b_wd[k*3+:3])));
      if (b_rav) sb(RB, "b_rd_addr", int'(b_ra));
      if (b_hv && b_hr) sb(HB, "b_pop_head", int'(b_head));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drv_a(input logic [2:0] v, input logic [2:0] i0, input logic [2:0] i1, input logic [2:0] i2, input logic hr);
    a_ntv = v; a_nt = {i2, i1, i0}; a_hr = hr;
  endtask
  task automatic drv_b(input logic [2:0] v, input logic [2:0] i0, input logic [2:0] i1, input logic [2:0] i2, input logic hr);
    b_ntv = v; b_nt = {i2, i1, i0}; b_hr = hr;
  endtask
  task automatic st_a(input string nm, input int hv, input int hd, input int cnt);
    chk({nm, "_hv"}, int'(a_hv), hv);
    if (hv == 1) chk({nm, "_head"}, int'(a_head), hd);
    chk({nm, "_count"}, int'(a_count), cnt);
  endtask
  task automatic st_b(input string nm, input int hv, input int hd, input int cnt);
    chk({nm, "_hv"}, int'(b_hv), hv);
    if (hv == 1) chk({nm, "_head"}, int'(b_head), hd);
    chk({nm, "_count"}, int'(b_count), cnt);
  endtask

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    drv_a(0, 0, 0, 0, 0); drv_b(0, 0, 0, 0, 0);
    repeat (2) step();
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    chk("a_reset_head", int'(a_head), 0);
    st_a("a_reset", 0, 0, 0);
    st_b("b_reset", 0, 0, 0);
    // first push into an empty list becomes head without a link write
    drv_a(3'b001, 5, 0, 0, 0); step(); drv_a(0, 0, 0, 0, 0);
    st_a("a_first_push", 1, 5, 1);
    q[WA].push_back(wr_code(0, 5, 2));
    drv_a(3'b001, 2, 0, 0, 0); step();
    q[WA].push_back(wr_code(0, 2, 4)); q[WA].push_back(wr_code(2, 4, 7));
    drv_a(3'b101, 4, 0, 7, 0); step();
    q[WA].push_back(wr_code(1, 7, 3));
    drv_a(3'b010, 0, 3, 0, 0); step(); drv_a(0, 0, 0, 0, 0);
    st_a("a_chain", 1, 5, 5);
    // back-to-back pops with zero read latency through 5->2->4->7->3
    foreach (q[RA][i]) ;
    q[RA].push_back(5); q[RA].push_back(2); q[RA].push_back(4); q[RA].push_back(7);
    q[HA].push_back(5); q[HA].push_back(2); q[HA].push_back(4); q[HA].push_back(7); q[HA].push_back(3);
    drv_a(0, 0, 0, 0, 1);
    step(); st_a("a_pop1", 1, 2, 4);
    step(); st_a("a_pop2", 1, 4, 3);
    step(); st_a("a_pop3", 1, 7, 2);
    step(); st_a("a_pop4", 1, 3, 1);
    step(); drv_a(0, 0, 0, 0, 0); st_a("a_pop5", 0, 0, 0);
    // list 1->4->0 popped on three consecutive cycles
    drv_a(3'b001, 1, 0, 0, 0); step();
    q[WA].push_back(wr_code(0, 1, 4)); q[WA].push_back(wr_code(1, 4, 0));
    drv_a(3'b011, 4, 0, 0, 0); step(); drv_a(0, 0, 0, 0, 0);
    st_a("a_l140", 1, 1, 3);
    q[RA].push_back(1); q[RA].push_back(4);
    q[HA].push_back(1); q[HA].push_back(4); q[HA].push_back(0);
    drv_a(0, 0, 0, 0, 1);
    step(); st_a("a_l140_p1", 1, 4, 2);
    step(); st_a("a_l140_p2", 1, 0, 1);
    step(); drv_a(0, 0, 0, 0, 0); st_a("a_l140_p3", 0, 0, 0);
    // last-entry pop with a same-cycle push bypasses the RAM
    drv_a(3'b001, 3, 0, 0, 0); step(); drv_a(0, 0, 0, 0, 0);
    st_a("a_byp_pre", 1, 3, 1);
    q[HA].push_back(3);
    drv_a(3'b010, 0, 6, 0, 1); step(); drv_a(0, 0, 0, 0, 0);
    st_a("a_bypass", 1, 6, 1);
    q[HA].push_back(6);
    drv_a(0, 0, 0, 0, 1); step(); drv_a(0, 0, 0, 0, 0);
    st_a("a_byp_drain", 0, 0, 0);
    // three ports into an empty list, then a pop concurrent with a push
    q[WA].push_back(wr_code(1, 1, 2)); q[WA].push_back(wr_code(2, 2, 3));
    drv_a(3'b111, 1, 2, 3, 0); step(); drv_a(0, 0, 0, 0, 0);
    st_a("a_3port", 1, 1, 3);
    q[WA].push_back(wr_code(2, 3, 5));
    q[RA].push_back(1); q[RA].push_back(2); q[RA].push_back(3);
    q[HA].push_back(1); q[HA].push_back(2); q[HA].push_back(3); q[HA].push_back(5);
    drv_a(3'b100, 0, 0, 5, 1); step(); drv_a(0, 0, 0, 0, 1);
    st_a("a_poppush", 1, 2, 3);
    step(); st_a("a_pp2", 1, 3, 2);
    step(); st_a("a_pp3", 1, 5, 1);
    step(); drv_a(0, 0, 0, 0, 0); st_a("a_pp4", 0, 0, 0);
    // two-cycle latency: pop waits in PEND while pushes keep linking
    q[WB].push_back(wr_code(1, 1, 4)); q[WB].push_back(wr_code(2, 4, 0));
    drv_b(3'b111, 1, 4, 0, 0); step(); drv_b(0, 0, 0, 0, 0);
    st_b("b_l140", 1, 1, 3);
    q[RB].push_back(1); q[HB].push_back(1);
    drv_b(0, 0, 0, 0, 1); step(); drv_b(0, 0, 0, 0, 0);
    st_b("b_pend1", 0, 0, 2);
    q[WB].push_back(wr_code(0, 0, 6));
    drv_b(3'b001, 6, 0, 0, 0); step(); drv_b(0, 0, 0, 0, 0);
    st_b("b_pend2", 0, 0, 3);
    step(); st_b("b_fetched", 1, 4, 3);
    // reset while a read is outstanding; the late response must be dropped
    q[RB].push_back(4); q[HB].push_back(4);
    drv_b(0, 0, 0, 0, 1); step(); drv_b(0, 0, 0, 0, 0);
    st_b("b_pend_rst_pre", 0, 0, 2);
    b_rst_n = 1'b0; #1;
    st_b("b_in_reset", 0, 0, 0);
    @(posedge clk); #1; b_rst_n = 1'b1;
    step(); st_b("b_late_drop", 0, 0, 0);
    chk("b_late_drop_head", int'(b_head), 0);
    drv_b(3'b001, 2, 0, 0, 0); step(); drv_b(0, 0, 0, 0, 0);
    st_b("b_after_rst", 1, 2, 1);
    q[HB].push_back(2);
    drv_b(0, 0, 0, 0, 1); step(); drv_b(0, 0, 0, 0, 0);
    st_b("b_final", 0, 0, 0);
    repeat (2) step();
    chk("a_wr_left", q[WA].size(), 0);
    chk("a_rd_left", q[RA].size(), 0);
    chk("a_head_left", q[HA].size(), 0);
    chk("b_wr_left", q[WB].size(), 0);
    chk("b_rd_left", q[RB].size(), 0);
    chk("b_head_left", q[HB].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
